// File: rtl/ppi_bus_master.sv
// Host-side initiator for an 8255A-style PPI bus. It turns valid/ready requests into
// timed read, write and Port C bit set/reset cycles, and tracks the last mode-set word.
module ppi_bus_master #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic       req_bsr,
    input  logic [1:0] req_addr,
    input  logic [7:0] req_wdata,
    input  logic [2:0] req_bit,
    input  logic       req_val,
    output logic       done,
    output logic [7:0] rsp_rdata,
    output logic [7:0] cw_shadow,
    output logic       nCs,
    output logic       nRe,
    output logic       nWr,
    output logic [1:0] A,
    inout  wire  [7:0] PD
);

    // A zero-cycle phase cannot be built, so it is stretched to one cycle.
    localparam int SETUP_EFF  = (SETUP_CYC  < 1) ? 1 : SETUP_CYC;
    localparam int STROBE_EFF = (STROBE_CYC < 1) ? 1 : STROBE_CYC;
    localparam int HOLD_EFF   = (HOLD_CYC   < 1) ? 1 : HOLD_CYC;

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_EFF  - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_EFF - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_EFF   - 1);

    localparam logic [7:0] CW_RESET = 8'h9B;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t     state_q;
    logic [3:0] cnt_q;
    logic       wr_q;
    logic       ncs_q;
    logic       nre_q;
    logic       nwr_q;
    logic [1:0] a_q;
    logic [7:0] pd_q;
    logic       pd_oe_q;
    logic       done_q;
    logic [7:0] rdata_q;
    logic [7:0] cw_q;

    assign req_ready = (state_q == IDLE) && !Reset;

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            ncs_q   <= 1'b1;
            nre_q   <= 1'b1;
            nwr_q   <= 1'b1;
            a_q     <= 2'b00;
            pd_q    <= 8'h00;
            pd_oe_q <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= 8'h00;
            cw_q    <= CW_RESET;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        // BSR is always a write of the composed bit command to the control register.
                        if (req_bsr) begin
                            wr_q    <= 1'b1;
                            a_q     <= 2'b11;
                            pd_q    <= {4'b0000, req_bit, req_val};
                            pd_oe_q <= 1'b1;
                        end else begin
                            wr_q    <= req_write;
                            a_q     <= req_addr;
                            pd_q    <= req_wdata;
                            pd_oe_q <= req_write;
                        end
                        ncs_q   <= 1'b0;
                        cnt_q   <= SETUP_LD;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_q == 4'd0) begin
                        nwr_q   <= !wr_q;
                        nre_q   <= wr_q;
                        cnt_q   <= STROBE_LD;
                        state_q <= STROBE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                STROBE: begin
                    if (cnt_q == 4'd0) begin
                        nwr_q   <= 1'b1;
                        nre_q   <= 1'b1;
                        if (!wr_q) begin
                            rdata_q <= PD;
                        end
                        cnt_q   <= HOLD_LD;
                        state_q <= HOLD;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                HOLD: begin
                    if (cnt_q == 4'd0) begin
                        ncs_q   <= 1'b1;
                        pd_oe_q <= 1'b0;
                        done_q  <= 1'b1;
                        // Only mode-set words (D7 = 1) reach the shadow; bit set/reset words do not.
                        if (wr_q && (a_q == 2'b11) && pd_q[7]) begin
                            cw_q <= pd_q;
                        end
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign PD        = pd_oe_q ? pd_q : 8'hzz;
    assign nCs       = ncs_q;
    assign nRe       = nre_q;
    assign nWr       = nwr_q;
    assign A         = a_q;
    assign done      = done_q;
    assign rsp_rdata = rdata_q;
    assign cw_shadow = cw_q;

    a_strobes_exclusive : assert property (@(posedge clk) disable iff (Reset) !(!nRe && !nWr));
    a_strobe_needs_cs   : assert property (@(posedge clk) disable iff (Reset) (!nRe || !nWr) |-> !nCs);

endmodule

// File: tb/tb_ppi_bus_master.sv
// Bench for ppi_bus_master: three instances with different phase timings, checked cycle
// by cycle against a phase-table model of the bus protocol.
module tb_ppi_bus_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       Reset;
    logic       req_valid [3];
    logic       req_write;
    logic       req_bsr;
    logic [1:0] req_addr;
    logic [7:0] req_wdata;
    logic [2:0] req_bit;
    logic       req_val;

    logic       ready_w [3];
    logic       done_w  [3];
    logic       ncs_w   [3];
    logic       nre_w   [3];
    logic       nwr_w   [3];
    logic [1:0] a_w     [3];
    logic [7:0] rdata_w [3];
    logic [7:0] cws_w   [3];

    wire  [7:0] pd0, pd1, pd2;

    // Bench side of the bus: a random probe value whenever the master should be off
    // the bus, and the peripheral read data while nRe is low.
    logic       tb_drv [3];
    logic [7:0] probe;
    logic [7:0] rd_val;

    assign pd0 = tb_drv[0] ? (nre_w[0] ? probe : rd_val) : 8'hzz;
    assign pd1 = tb_drv[1] ? (nre_w[1] ? probe : rd_val) : 8'hzz;
    assign pd2 = tb_drv[2] ? (nre_w[2] ? probe : rd_val) : 8'hzz;

    ppi_bus_master #(.SETUP_CYC(1), .STROBE_CYC(2), .HOLD_CYC(1)) u_def (
        .clk(clk), .Reset(Reset), .req_valid(req_valid[0]), .req_ready(ready_w[0]),
        .req_write(req_write), .req_bsr(req_bsr), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_bit(req_bit), .req_val(req_val), .done(done_w[0]), .rsp_rdata(rdata_w[0]),
        .cw_shadow(cws_w[0]), .nCs(ncs_w[0]), .nRe(nre_w[0]), .nWr(nwr_w[0]), .A(a_w[0]),
        .PD(pd0));

    ppi_bus_master #(.SETUP_CYC(3), .STROBE_CYC(4), .HOLD_CYC(2)) u_slow (
        .clk(clk), .Reset(Reset), .req_valid(req_valid[1]), .req_ready(ready_w[1]),
        .req_write(req_write), .req_bsr(req_bsr), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_bit(req_bit), .req_val(req_val), .done(done_w[1]), .rsp_rdata(rdata_w[1]),
        .cw_shadow(cws_w[1]), .nCs(ncs_w[1]), .nRe(nre_w[1]), .nWr(nwr_w[1]), .A(a_w[1]),
        .PD(pd1));

    ppi_bus_master #(.SETUP_CYC(0), .STROBE_CYC(0), .HOLD_CYC(0)) u_zero (
        .clk(clk), .Reset(Reset), .req_valid(req_valid[2]), .req_ready(ready_w[2]),
        .req_write(req_write), .req_bsr(req_bsr), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_bit(req_bit), .req_val(req_val), .done(done_w[2]), .rsp_rdata(rdata_w[2]),
        .cw_shadow(cws_w[2]), .nCs(ncs_w[2]), .nRe(nre_w[2]), .nWr(nwr_w[2]), .A(a_w[2]),
        .PD(pd2));

    // Effective phase lengths per instance; the zero-parameter instance runs as 1/1/1.
    localparam int SP [3] = '{1, 3, 1};
    localparam int TP [3] = '{2, 4, 1};
    localparam int HP [3] = '{1, 2, 1};

    logic [7:0] cw_m [3];
    logic [7:0] rd_m [3];

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pd_of(input int inst);
        case (inst)
            0:       return pd0;
            1:       return pd1;
            default: return pd2;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            cw_m[i] = 8'h9B;
            rd_m[i] = 8'h00;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++)
                chk($sformatf("idle i%0d", i),
                    {ncs_w[i], nre_w[i], nwr_w[i], done_w[i], ready_w[i]}, 5'b11101);
        end
    endtask

    // Called just after a negedge; presents the request at once and returns at the
    // negedge of the done cycle, so a following call is accepted on that done cycle.
    task automatic run_op(input int inst, input bit wr, input bit bsr, input logic [1:0] addr,
                          input logic [7:0] wd, input logic [2:0] b, input bit v,
                          input logic [7:0] rv);
        bit         is_wr;
        logic [1:0] ea;
        logic [7:0] ed;
        logic [7:0] exp_pd;
        int         s, t, n, ph;
        bit         e_nre, e_nwr;
        is_wr = bsr ? 1'b1 : wr;
        ea    = bsr ? 2'b11 : addr;
        ed    = bsr ? {4'b0000, b, v} : wd;
        s = SP[inst];
        t = TP[inst];
        n = s + t + HP[inst];

        chk($sformatf("i%0d ready_before", inst), ready_w[inst], 1'b1);
        rd_val = rv;
        probe  = 8'($urandom);
        tb_drv[inst] = !is_wr;
        req_write = wr; req_bsr = bsr; req_addr = addr; req_wdata = wd;
        req_bit = b; req_val = v; req_valid[inst] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[inst] = 1'b0;
        req_write = 1'($urandom); req_bsr = 1'($urandom); req_addr = 2'($urandom);
        req_wdata = 8'($urandom); req_bit = 3'($urandom); req_val = 1'($urandom);

        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            ph = (k <= s) ? 0 : ((k <= s + t) ? 1 : 2);
            e_nre = !(ph == 1 && !is_wr);
            e_nwr = !(ph == 1 && is_wr);
            chk($sformatf("i%0d k%0d bus", inst, k),
                {ready_w[inst], ncs_w[inst], nre_w[inst], nwr_w[inst], a_w[inst], done_w[inst]},
                {1'b0, 1'b0, e_nre, e_nwr, ea, 1'b0});
            exp_pd = is_wr ? ed : ((ph == 1) ? rv : probe);
            chk($sformatf("i%0d k%0d pd", inst, k), pd_of(inst), exp_pd);
            if (k == 1) begin
                chk($sformatf("i%0d rdata_held", inst), rdata_w[inst], rd_m[inst]);
                chk($sformatf("i%0d cw_held", inst), cws_w[inst], cw_m[inst]);
            end
            if (k == n && is_wr) tb_drv[inst] = 1'b1;
        end

        if (!is_wr) rd_m[inst] = rv;
        if (is_wr && ea == 2'b11 && ed[7]) cw_m[inst] = ed;

        @(negedge clk);
        chk($sformatf("i%0d done_cycle", inst),
            {ncs_w[inst], nre_w[inst], nwr_w[inst], done_w[inst], ready_w[inst]}, 5'b11111);
        chk($sformatf("i%0d pd_released", inst), pd_of(inst), probe);
        chk($sformatf("i%0d rdata", inst), rdata_w[inst], rd_m[inst]);
        chk($sformatf("i%0d cw_shadow", inst), cws_w[inst], cw_m[inst]);
    endtask

    // Write to instance 0 with Reset raised during its first strobe cycle.
    task automatic reset_mid();
        tb_drv[0] = 1'b0;
        probe = 8'($urandom);
        req_write = 1'b1; req_bsr = 1'b0; req_addr = 2'b11; req_wdata = 8'hA7;
        req_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid strobe_low", {ncs_w[0], nwr_w[0]}, 2'b00);
        Reset = 1'b1;
        tb_drv[0] = 1'b1;
        @(negedge clk);
        model_reset();
        chk("rst_mid bus", {ncs_w[0], nre_w[0], nwr_w[0], done_w[0], ready_w[0]}, 5'b11100);
        chk("rst_mid pd", pd0, probe);
        chk("rst_mid rdata", rdata_w[0], rd_m[0]);
        chk("rst_mid cw", cws_w[0], cw_m[0]);
        Reset = 1'b0;
        idle(3);
    endtask

    initial begin
        int  inst, kind;
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_valid[i] = 1'b0;
            tb_drv[i]    = 1'b1;
        end
        req_write = 1'b0; req_bsr = 1'b0; req_addr = 2'b00; req_wdata = 8'h00;
        req_bit = 3'd0; req_val = 1'b0;
        probe = 8'h3E; rd_val = 8'h00;
        model_reset();

        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset i%0d bus", i), {ncs_w[i], nre_w[i], nwr_w[i], done_w[i]}, 4'b1110);
            chk($sformatf("reset i%0d pd", i), pd_of(i), probe);
            chk($sformatf("reset i%0d cw", i), cws_w[i], 8'h9B);
            chk($sformatf("reset i%0d rdata", i), rdata_w[i], 8'h00);
        end
        Reset = 1'b0;
        idle(1);

        run_op(0, 1'b1, 1'b0, 2'b11, 8'h80, 3'd0, 1'b0, 8'h00);
        idle(1);
        run_op(0, 1'b0, 1'b0, 2'b01, 8'h00, 3'd0, 1'b0, 8'h5A);
        idle(1);
        run_op(0, 1'b0, 1'b1, 2'b00, 8'hFF, 3'd5, 1'b1, 8'h00);
        run_op(0, 1'b0, 1'b0, 2'b10, 8'h00, 3'd0, 1'b0, 8'hC3);
        idle(1);
        run_op(1, 1'b1, 1'b0, 2'b00, 8'h3C, 3'd0, 1'b0, 8'h00);
        idle(1);
        run_op(1, 1'b0, 1'b0, 2'b10, 8'h00, 3'd0, 1'b0, 8'h96);
        idle(1);
        run_op(2, 1'b1, 1'b0, 2'b11, 8'h92, 3'd0, 1'b0, 8'h00);
        run_op(2, 1'b0, 1'b0, 2'b00, 8'h00, 3'd0, 1'b0, 8'h21);
        idle(1);

        reset_mid();
        run_op(0, 1'b1, 1'b0, 2'b11, 8'h95, 3'd0, 1'b0, 8'h00);
        idle(1);

        repeat (80) begin
            inst = $urandom_range(0, 2);
            kind = $urandom_range(0, 3);
            case (kind)
                0: run_op(inst, 1'b1, 1'b0, 2'($urandom), 8'($urandom), 3'd0, 1'b0, 8'h00);
                1: run_op(inst, 1'b1, 1'b0, 2'b11, 8'($urandom), 3'd0, 1'b0, 8'h00);
                2: run_op(inst, 1'($urandom), 1'b1, 2'($urandom), 8'($urandom),
                          3'($urandom), 1'($urandom), 8'h00);
                default: run_op(inst, 1'b0, 1'b0, 2'($urandom), 8'($urandom), 3'd0, 1'b0,
                                8'($urandom));
            endcase
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
